// File: rtl/secuenciador_filtro.sv
// Sequencing FSM for the second-order filter: load, MAC over all terms, pipeline wait, shift, done.
// Optional ovr_count output (dropped-tick counter) is built when SECUENCIADOR_OVR_CNT_EN is defined.
`timescale 1ns/1ps
module secuenciador_filtro #(
  parameter int N       = 25,
  parameter int NTERM   = 5,
  parameter int MAC_LAT = 1,
  parameter int TERM_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sample_tick,
  input  logic              clr_err,
  output logic              ld_in,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [TERM_W-1:0] term_sel,
  output logic              shift,
  output logic              out_valid,
  output logic              busy,
`ifdef SECUENCIADOR_OVR_CNT_EN
  output logic [7:0]        ovr_count,
`endif
  output logic              overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int                WAIT_W    = 3;
  localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(NTERM - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MAC_LAT - 1);

  if (N < 1 || NTERM < 2 || NTERM > 8 || (1 << TERM_W) < NTERM || MAC_LAT < 1 || MAC_LAT > 7)
  begin : g_bad_params
    $error("secuenciador_filtro: illegal parameter combination");
  end

  logic [2:0]        state_q, state_d;
  logic [TERM_W-1:0] term_q, term_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              overrun_q, overrun_d;
  logic              accept, drop;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    accept  = sample_tick && en;
    drop    = sample_tick && (state_q inside {S_LOAD, S_MAC, S_WAIT, S_SHIFT});
    state_d = state_q;
    term_d  = term_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD: begin
        term_d  = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        term_d = term_q + 1'b1;
        if (term_q == TERM_LAST) begin
          state_d = S_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_SHIFT;
        else              wait_d  = wait_q - 1'b1;
      end
      S_SHIFT: state_d = S_DONE;
      S_DONE:  state_d = accept ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A dropped tick outranks a clear arriving in the same cycle.
    overrun_d = drop ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      term_q    <= '0;
      wait_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      wait_q    <= wait_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SECUENCIADOR_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (clr_err)                      ovr_cnt_d = drop ? 8'd1 : 8'd0;
    else if (drop && ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_cnt_q <= '0;
    else       ovr_cnt_q <= ovr_cnt_d;
  end

  assign ovr_count = ovr_cnt_q;
`endif

  // Outputs decode the state register only, so reset clears them without waiting for a clock.
  assign ld_in     = (state_q == S_LOAD);
  assign mac_clr   = (state_q == S_LOAD);
  assign mac_en    = (state_q == S_MAC);
  assign term_sel  = (state_q == S_MAC) ? term_q : '0;
  assign shift     = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Directed bench for secuenciador_filtro: default build (a) and an NTERM=3/MAC_LAT=3 build (b) share stimulus.
`timescale 1ns/1ps
module tb_secuenciador_filtro;

  typedef struct packed {
    logic       ld_in;
    logic       mac_clr;
    logic       mac_en;
    logic [2:0] term_sel;
    logic       shift;
    logic       out_valid;
    logic       busy;
    logic       overrun;
  } obs_t;

  logic clk = 1'b0;
  logic reset, en, sample_tick, clr_err;
  logic a_ld, a_clr, a_en, a_sh, a_ov, a_busy, a_ovr;
  logic b_ld, b_clr, b_en, b_sh, b_ov, b_busy, b_ovr;
  logic [2:0] a_ts, b_ts;
`ifdef SECUENCIADOR_OVR_CNT_EN
  logic [7:0] a_cnt, b_cnt;
`endif
  obs_t oa, ob;

  int n_vec = 0, n_err = 0;
  int shift_a = 0, ov_a = 0, ld_a = 0, shift_b = 0, ov_b = 0, overlap = 0;

  always #5 clk = ~clk;

  secuenciador_filtro dut_a (
    .clk(clk), .reset(reset), .en(en), .sample_tick(sample_tick), .clr_err(clr_err),
    .ld_in(a_ld), .mac_clr(a_clr), .mac_en(a_en), .term_sel(a_ts), .shift(a_sh),
    .out_valid(a_ov), .busy(a_busy),
`ifdef SECUENCIADOR_OVR_CNT_EN
    .ovr_count(a_cnt),
`endif
    .overrun(a_ovr)
  );

  secuenciador_filtro #(.NTERM(3), .MAC_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .en(en), .sample_tick(sample_tick), .clr_err(clr_err),
    .ld_in(b_ld), .mac_clr(b_clr), .mac_en(b_en), .term_sel(b_ts), .shift(b_sh),
    .out_valid(b_ov), .busy(b_busy),
`ifdef SECUENCIADOR_OVR_CNT_EN
    .ovr_count(b_cnt),
`endif
    .overrun(b_ovr)
  );

  assign oa = {a_ld, a_clr, a_en, a_ts, a_sh, a_ov, a_busy, a_ovr};
  assign ob = {b_ld, b_clr, b_en, b_ts, b_sh, b_ov, b_busy, b_ovr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the rising edge, then observe on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    shift_a += int'(a_sh);
    ov_a    += int'(a_ov);
    ld_a    += int'(a_ld);
    shift_b += int'(b_sh);
    ov_b    += int'(b_ov);
    if (int'(a_ld) + int'(a_en) + int'(a_sh) > 1) overlap++;
    if (int'(b_ld) + int'(b_en) + int'(b_sh) > 1) overlap++;
  endtask

  // Issue one tick from IDLE and compare every cycle against the expected schedule.
  task automatic run_seq(input int sel, input int nt, input int ml, input int drop_en_k);
    obs_t e;
    sample_tick = 1'b1;
    for (int k = 1; k <= nt + ml + 4; k++) begin
      step();
      sample_tick = 1'b0;
      if (k == drop_en_k) en = 1'b0;
      e           = '0;
      e.ld_in     = (k == 1);
      e.mac_clr   = (k == 1);
      e.mac_en    = (k >= 2) && (k <= 1 + nt);
      e.term_sel  = e.mac_en ? 3'(k - 2) : 3'd0;
      e.shift     = (k == 2 + nt + ml);
      e.out_valid = (k == 3 + nt + ml);
      e.busy      = (k <= 3 + nt + ml);
      check($sformatf("seq dut%0d k=%0d", sel, k), 32'(sel != 0 ? ob : oa), 32'(e));
    end
    en = 1'b1;
  endtask

  initial begin
    int s0, o0, l0, sb0, ob0;
    reset = 1'b1; en = 1'b1; sample_tick = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset a", 32'(oa), 32'd0);
    check("reset b", 32'(ob), 32'd0);
    reset = 1'b0;
    step();
    step();

    // Single tick on the default build
    run_seq(0, 5, 1, 0);

    // Twenty ticks at the minimum period
    s0 = shift_a; o0 = ov_a; l0 = ld_a; sb0 = shift_b; ob0 = ov_b;
    for (int i = 0; i < 180; i++) begin
      sample_tick = (i % 9 == 0);
      step();
    end
    sample_tick = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("burst shifts a", 32'(shift_a - s0), 32'd20);
    check("burst valids a", 32'(ov_a - o0), 32'd20);
    check("burst loads a", 32'(ld_a - l0), 32'd20);
    check("burst overrun a", 32'(a_ovr), 32'd0);
    check("burst shifts b", 32'(shift_b - sb0), 32'd20);
    check("burst valids b", 32'(ov_b - ob0), 32'd20);
    check("burst overrun b", 32'(b_ovr), 32'd0);

    // Overrun: second tick lands mid-sequence
    s0 = shift_a;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step(); step(); step();
    check("pre-drop overrun", 32'(a_ovr), 32'd0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("overrun set a", 32'(a_ovr), 32'd1);
    check("overrun set b", 32'(b_ovr), 32'd1);
    for (int i = 0; i < 25; i++) step();
    check("overrun held a", 32'(a_ovr), 32'd1);
    check("overrun held b", 32'(b_ovr), 32'd1);
`ifdef SECUENCIADOR_OVR_CNT_EN
    check("ovr_count a", 32'(a_cnt), 32'd1);
    check("ovr_count b", 32'(b_cnt), 32'd1);
`endif
    check("dropped tick no shift", 32'(shift_a - s0), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("overrun clr a", 32'(a_ovr), 32'd0);
    check("overrun clr b", 32'(b_ovr), 32'd0);
`ifdef SECUENCIADOR_OVR_CNT_EN
    check("ovr_count clr a", 32'(a_cnt), 32'd0);
    check("ovr_count clr b", 32'(b_cnt), 32'd0);
`endif

    // Disabled tick is ignored, then en falls mid-MAC without aborting
    en = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("en0 busy", 32'(a_busy), 32'd0);
    check("en0 ld_in", 32'(a_ld), 32'd0);
    check("en0 overrun", 32'(a_ovr), 32'd0);
    step();
    en = 1'b1;
    run_seq(0, 5, 1, 3);

    // Asynchronous reset during MAC term 2
    s0 = shift_a;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step(); step(); step();
    check("pre-reset term_sel", 32'(a_ts), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async reset a", 32'(oa), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("no shift after abort", 32'(shift_a - s0), 32'd0);
    check("idle after abort", 32'(a_busy), 32'd0);
    run_seq(0, 5, 1, 0);

    // Alternate build: three terms, three-cycle MAC latency
    run_seq(1, 3, 3, 0);

    check("enable overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/secuenciador_filtro.md
Name: secuenciador_filtro

Overview:
- FSM controller for the second-order fixed-point filter datapath.
- On each sample tick it loads the new input, steps the shared MAC through every coefficient term, waits out the MAC pipeline, then pulses `shift` into the f(k)/f(k-1)/f(k-2) delay lines and flags the output as valid.
- Sits between the sample-rate timebase and the delay-line/MAC datapath.
- Also detects sample overruns.

Parameters:
- N, 25, datapath half-width; informational only, no port depends on it.
- NTERM, 5, number of MAC terms per sample: b0·x(k), b1·x(k-1), b2·x(k-2), a1·y(k-1), a2·y(k-2). Legal range 2..8.
- MAC_LAT, 1, MAC pipeline latency in cycles, from the last mac_en to a valid accumulator. Legal range 1..7.
- TERM_W, 3, width of term_sel; must satisfy 2^TERM_W >= NTERM.

Ports:
- clk, input, 1, system clock; all state changes on posedge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- en, input, 1, global enable; sampled only in IDLE/DONE.
- sample_tick, input, 1, single-cycle pulse requesting one filter iteration.
- clr_err, input, 1, synchronous clear of overrun (and of ovr_count when enabled).
- ld_in, output, 1, load the new sample into the datapath input register.
- mac_clr, output, 1, clear the MAC accumulator.
- mac_en, output, 1, accumulate term term_sel this cycle.
- term_sel, output, TERM_W, selects the coefficient/operand pair for the MAC.
- shift, output, 1, shift enable to the x and y delay lines.
- out_valid, output, 1, one-cycle pulse: filter output y(k) is valid.
- busy, output, 1, high in every state except IDLE.
- overrun, output, 1, sticky flag: a tick arrived while the block could not accept it.

Behaviour:
- Reset values: state = IDLE; all outputs 0; term counter 0; wait counter 0; overrun 0.
- All outputs are registered or decoded from state only; no combinational input-to-output path.
- Accepting a tick: a tick is accepted when sample_tick=1 && en=1 in IDLE or DONE. The next state is then LOAD.
- IDLE:
  - busy=0.
  - Stays in IDLE when en=0 (ticks ignored, no overrun) or when there is no tick.
- LOAD (1 cycle):
  - ld_in=1, mac_clr=1.
  - term counter cleared.
  - Next state: MAC.
- MAC (NTERM cycles):
  - mac_en=1, term_sel = counter 0, 1, .., NTERM-1.
  - Counter increments each cycle.
  - When counter = NTERM-1: go to WAIT, load wait counter with MAC_LAT-1.
- WAIT (MAC_LAT cycles):
  - mac_en=0, term_sel=0.
  - Decrement the wait counter; at 0 go to SHIFT.
- SHIFT (1 cycle):
  - shift=1.
  - Next state: DONE.
- DONE (1 cycle):
  - out_valid=1.
  - Next state: LOAD if a tick is accepted, otherwise IDLE.
  - busy=1 in DONE.
- Latency:
  - tick sampled high at edge t → ld_in at t+1, first mac_en at t+2, shift at t+2+NTERM+MAC_LAT, out_valid one cycle later.
  - Defaults: shift at t+8, out_valid at t+9.
  - Minimum tick period with no overrun: NTERM+MAC_LAT+3 cycles (9 at defaults).
- Overrun:
  - sample_tick=1 in LOAD, MAC, WAIT or SHIFT sets overrun (regardless of en). The tick is dropped and the sequence is unaffected.
  - overrun holds until clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- Disabling mid-sequence: en falling during LOAD..SHIFT does not abort; the iteration completes through DONE, then returns to IDLE.
- Reset mid-sequence: immediate return to IDLE, outputs 0. No shift pulse is generated for the aborted sample.
- Glitch-free enables: mac_en, shift and ld_in are never asserted in the same cycle.

Optional Feature:
- Macro: SECUENCIADOR_OVR_CNT_EN.
- Defined:
  - Adds output `ovr_count` [7:0], counting dropped ticks.
  - Saturates at 255.
  - Cleared by reset and by clr_err; an increment in the same cycle as clr_err wins, giving 1.
- Undefined: the port and counter are absent; overrun behaviour is otherwise identical.

Test Plan:
- Reset then a single tick at cycle 10 (en=1, defaults):
  - ld_in=1 and mac_clr=1 at cycle 11.
  - mac_en=1 at cycles 12–16, term_sel = 0, 1, 2, 3, 4.
  - shift=1 at cycle 18; out_valid=1 at cycle 19; busy=0 from cycle 20.
- Ticks every 9 cycles for 20 samples:
  - Exactly 20 shift and 20 out_valid pulses.
  - DONE→LOAD back-to-back; overrun stays 0.
- Tick at cycle 0 and a second tick at cycle 4:
  - Second tick dropped; overrun=1 from cycle 5 and held.
  - clr_err at cycle 30 → overrun=0 at cycle 31.
  - With SECUENCIADOR_OVR_CNT_EN: ovr_count = 1, then 0.
- en=0 with a tick in IDLE: no state change, overrun=0. en dropped during MAC: sequence still reaches out_valid, then IDLE.
- reset asserted asynchronously mid-MAC (term_sel=2):
  - All outputs 0 immediately; state IDLE; no shift pulse.
  - The next tick starts cleanly at LOAD.
- NTERM=3, MAC_LAT=3: mac_en for 3 cycles, 3 wait cycles; shift at t+8, out_valid at t+9.
